pipelined_barrel_shifter: RTL and testbench
===========================================

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 Parameter N, default 8: data width in bits; SHALL be >= 2 and a power of two.
REQ-002 Parameter SW, default $clog2(N): shift-amount width and number of shift layers.
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 IN_VALID  input  1  operand present on IN/SHAMT/MODE.
REQ-006 IN_READY  output  1  block accepts the operand this cycle.
REQ-007 IN  input  N  operand.
REQ-008 SHAMT  input  SW  shift amount, 0..N-1.
REQ-009 MODE  input  2  operation: 00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right.
REQ-010 OUT_VALID  output  1  result present on OUT.
REQ-011 OUT_READY  input  1  consumer accepts the result.
REQ-012 OUT  output  N  shifted result.

Function
REQ-013 One layer per SHAMT bit; layer k SHALL shift by 2**k when SHAMT[k]=1 and pass data through otherwise, then register its result.
REQ-014 Each stage register SHALL hold data, remaining SHAMT bits, MODE, sign bit and a valid flag.
REQ-015 Latency SHALL be exactly SW cycles from the accept edge to OUT_VALID=1 when OUT_READY is held 1.
REQ-016 Throughput SHALL be one operation per cycle without backpressure.
REQ-017 Transfer occurs on a rising edge where VALID=1 and READY=1 on the same port.
REQ-018 Stage k SHALL load when it is empty or its downstream stage loads in the same cycle; IN_READY is stage-0 load permission.
REQ-019 OUT_VALID/OUT SHALL stay stable while OUT_VALID=1 and OUT_READY=0.
REQ-020 When the pipeline is full and OUT_READY=1, IN_READY SHALL be 1 the same cycle (no bubble on simultaneous push and pop).
REQ-021 Logical right and logical left SHALL zero-fill; arithmetic right SHALL fill with IN[N-1] captured at accept.
REQ-022 Left shift SHALL be implemented as bit-reverse on entry, right shift, bit-reverse on exit.
REQ-023 SHAMT=0 SHALL return IN unchanged in every mode.
REQ-024 Zero fill beyond bit N-1 SHALL never read out-of-range indices.
REQ-025 OUT SHALL be 0 whenever OUT_VALID=0.

Reset
REQ-026 While RST_N=0: all valid flags 0, OUT_VALID=0, OUT=0, IN_READY=0, all stage data 0.
REQ-027 Assertion mid-operation SHALL discard all in-flight operations immediately, with no output produced for them.
REQ-028 IN_READY SHALL become 1 on the first rising edge after RST_N deasserts.

Configuration
REQ-029 Macro SHIFTER_ROTATE_EN enables rotate.
REQ-030 With SHIFTER_ROTATE_EN defined, MODE=11 SHALL rotate right, with bits leaving at bit 0 re-entering at bit N-1.
REQ-031 With SHIFTER_ROTATE_EN undefined, MODE=11 SHALL behave exactly as MODE=00 and no wrap-around mux logic SHALL be synthesised.

Structure
REQ-032 Package shifter_pkg SHALL hold the mode_t enum (SH_LSR, SH_ASR, SH_LSL, SH_ROR) and the stage record typedef.
REQ-033 Sub-module shifter_stage SHALL implement one layer (per-bit 2:1 select, fill select, register, valid/ready); it SHALL be instantiated SW times by generate, with parameter STEP=2**k.

Verification
REQ-034 N=8, IN=8'b1001_0110, SHAMT=3, MODE=00, OUT_READY=1 -> OUT=8'b0001_0010 exactly 3 cycles after accept.
REQ-035 IN=8'h96, SHAMT=2, MODE=01 -> OUT=8'hE5; IN=8'h96, SHAMT=2, MODE=10 -> OUT=8'h58.
REQ-036 ROTATE_EN defined: IN=8'h81, SHAMT=1, MODE=11 -> OUT=8'hC0; undefined: same stimulus -> OUT=8'h40.
REQ-037 Back-to-back stream of 8 operands, OUT_READY low for cycles 4-7 -> IN_READY drops once the pipeline fills, OUT is held stable, and all 8 results emerge in order with none lost or duplicated.
REQ-038 RST_N pulsed low for 1 cycle with 3 operations in flight -> OUT_VALID is 0 immediately, no stale results appear afterwards, and a new operand completes with 3-cycle latency.
REQ-039 Random mode/SHAMT/IN with random OUT_READY, 10k ops, compared against a reference model -> zero mismatches.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter: operation encoding,
// per-stage control record and the fill-bit rule used by every layer.
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_LSR = 2'b00,
        SH_ASR = 2'b01,
        SH_LSL = 2'b10,
        SH_ROR = 2'b11
    } mode_t;

    // Width-independent part of a stage record; data and remaining shift
    // amount are sized by the block parameters and travel alongside it.
    typedef struct packed {
        mode_t mode;
        logic  sign;
        logic  valid;
    } stage_ctl_t;

    localparam stage_ctl_t CTL_IDLE = '{mode: SH_LSR, sign: 1'b0, valid: 1'b0};

    function automatic logic fill_bit(input mode_t mode, input logic sign);
        return (mode == SH_ASR) ? sign : 1'b0;
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// One barrel-shifter layer: optional right shift by STEP, fill select and a
// valid/ready stage register. SHIFTER_ROTATE_EN adds the wrap-around path.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int N    = 8,
    parameter int SW   = $clog2(N),
    parameter int STEP = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_shamt,
    input  logic [1:0]    up_mode,
    input  logic          up_sign,
    output logic          dn_valid,
    input  logic          dn_ready,
    output logic [N-1:0]  dn_data,
    output logic [SW-1:0] dn_shamt,
    output logic [1:0]    dn_mode,
    output logic          dn_sign
);

    localparam int K = $clog2(STEP);

    mode_t         mode_e;
    logic          fill;
    logic          load;
    logic [N-1:0]  shifted;
    logic [N-1:0]  next_data;
    logic [N-1:0]  data_q;
    logic [SW-1:0] shamt_q;
    stage_ctl_t    ctl_q;

    assign mode_e = mode_t'(up_mode);
    assign fill   = fill_bit(mode_e, up_sign);

    // Bits that would come from beyond bit N-1 take the fill (or wrap)
    // value; the index split is resolved at elaboration time.
    for (genvar i = 0; i < N; i++) begin : g_bit
        if (i + STEP < N) begin : g_inner
            assign shifted[i] = up_data[i + STEP];
        end else begin : g_edge
`ifdef SHIFTER_ROTATE_EN
            assign shifted[i] = (mode_e == SH_ROR) ? up_data[i + STEP - N] : fill;
`else
            assign shifted[i] = fill;
`endif
        end
    end

    assign next_data = up_shamt[K] ? shifted : up_data;
    assign load      = !ctl_q.valid || dn_ready;

    // NOTE: non-blocking (<=) on every register so each stage samples its
    // neighbour's pre-edge value; blocking here would race between stages.
    // NOTE: datapath registers are reset too, so a mid-operation reset
    // leaves nothing stale that could later reach the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            shamt_q <= '0;
            ctl_q   <= CTL_IDLE;
        end else if (load) begin
            ctl_q.valid <= up_valid;
            if (up_valid) begin
                data_q     <= next_data;
                shamt_q    <= up_shamt;
                ctl_q.mode <= mode_e;
                ctl_q.sign <= up_sign;
            end
        end
    end

    assign dn_valid = ctl_q.valid;
    assign dn_data  = data_q;
    assign dn_shamt = shamt_q;
    assign dn_mode  = ctl_q.mode;
    assign dn_sign  = ctl_q.sign;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SW registered layers with valid/ready at both ends.
// Define SHIFTER_ROTATE_EN for MODE=11 rotate-right; otherwise MODE=11 is a logical right shift.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in,
    input  logic [SW-1:0] shamt,
    input  logic [1:0]    mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out
);

    logic          started;
    logic [N-1:0]  in_rev;
    logic [N-1:0]  tail_rev;
    logic [SW:0]   v_chain;
    logic [SW:0]   rdy;
    logic [N-1:0]  stg_data  [SW+1];
    logic [SW-1:0] stg_shamt [SW+1];
    logic [1:0]    stg_mode  [SW+1];
    logic          stg_sign  [SW+1];
    logic          unused_tail;

    // Holds in_ready low through reset and until the first edge after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_rev
        assign in_rev[i]   = in[N-1-i];
        assign tail_rev[i] = stg_data[SW][N-1-i];
    end

    // Left shift runs through the right-shift layers on bit-reversed data.
    assign v_chain[0]   = in_valid && started;
    assign stg_data[0]  = (mode_t'(mode) == SH_LSL) ? in_rev : in;
    assign stg_shamt[0] = shamt;
    assign stg_mode[0]  = mode;
    assign stg_sign[0]  = in[N-1];

    // Stage k can load when the consumer takes the result or any stage from
    // k onwards has a hole; written flat so ready never loops through itself.
    assign rdy[SW]  = out_ready;
    assign in_ready = started && rdy[0];

    for (genvar k = 0; k < SW; k++) begin : g_stage
        assign rdy[k] = out_ready || !(&v_chain[SW:k+1]);

        shifter_stage #(
            .N    (N),
            .SW   (SW),
            .STEP (1 << k)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (v_chain[k]),
            .up_data  (stg_data[k]),
            .up_shamt (stg_shamt[k]),
            .up_mode  (stg_mode[k]),
            .up_sign  (stg_sign[k]),
            .dn_valid (v_chain[k+1]),
            .dn_ready (rdy[k+1]),
            .dn_data  (stg_data[k+1]),
            .dn_shamt (stg_shamt[k+1]),
            .dn_mode  (stg_mode[k+1]),
            .dn_sign  (stg_sign[k+1])
        );
    end

    assign out_valid = v_chain[SW];

    // NOTE: out gets a default before any condition, so every path assigns
    // it and no latch is inferred.
    always_comb begin
        out = '0;
        if (v_chain[SW]) begin
            out = (mode_t'(stg_mode[SW]) == SH_LSL) ? tail_rev : stg_data[SW];
        end
    end

    assign unused_tail = ^{stg_shamt[SW], stg_sign[SW]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (N=8): directed vectors,
// back-pressure, mid-operation reset and a randomized stream against a model.
`timescale 1ns/1ps
module tb_pipelined_barrel_shifter;

    localparam int N  = 8;
    localparam int SW = 3;

`ifdef SHIFTER_ROTATE_EN
    localparam logic [7:0] EXP_ROR_81_1 = 8'hC0;
    localparam logic [7:0] EXP_ROR_01_7 = 8'h02;
`else
    localparam logic [7:0] EXP_ROR_81_1 = 8'h40;
    localparam logic [7:0] EXP_ROR_01_7 = 8'h00;
`endif

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_data   = '0;
    logic [SW-1:0] in_shamt  = '0;
    logic [1:0]    in_mode   = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  out_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_data),
        .shamt     (in_shamt),
        .mode      (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_data)
    );

    // Reference: plain shift operators on the operand as a whole.
    function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] s,
                                             input logic [1:0] m);
        logic signed [7:0] sd;
        sd = d;
        case (m)
            2'b00:   return d >> s;
            2'b01:   return sd >>> s;
            2'b10:   return d << s;
            default: begin
`ifdef SHIFTER_ROTATE_EN
                return (d >> s) | (d << (8 - int'(s)));
`else
                return d >> s;
`endif
            end
        endcase
    endfunction

    // Single operation with out_ready held high; starts and ends at a negedge.
    // lat = rising edges from the accept edge to the edge that transfers the result.
    task automatic run_single(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m,
                              output logic [7:0] res, output int lat);
        int waitc = 0;
        in_data = d; in_shamt = s; in_mode = m; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        while (!in_ready && waitc < 10) begin
            @(negedge clk); #1; waitc++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        res = out_data;
        lat = lat + 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %h want 00", out_data); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b want 0", in_ready); end
        @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge: got %b want 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_directed();
        typedef struct packed {
            logic [7:0] d;
            logic [2:0] s;
            logic [1:0] m;
            logic [7:0] exp;
        } vec_t;
        vec_t       vecs [13];
        logic [7:0] res;
        int         lat;
        vecs[0]  = '{8'h96, 3'd3, 2'b00, 8'h12};
        vecs[1]  = '{8'h96, 3'd2, 2'b01, 8'hE5};
        vecs[2]  = '{8'h96, 3'd2, 2'b10, 8'h58};
        vecs[3]  = '{8'h81, 3'd1, 2'b11, EXP_ROR_81_1};
        vecs[4]  = '{8'h96, 3'd0, 2'b00, 8'h96};
        vecs[5]  = '{8'h96, 3'd0, 2'b01, 8'h96};
        vecs[6]  = '{8'h96, 3'd0, 2'b10, 8'h96};
        vecs[7]  = '{8'h96, 3'd0, 2'b11, 8'h96};
        vecs[8]  = '{8'h80, 3'd7, 2'b01, 8'hFF};
        vecs[9]  = '{8'hFF, 3'd7, 2'b10, 8'h80};
        vecs[10] = '{8'h01, 3'd7, 2'b11, EXP_ROR_01_7};
        vecs[11] = '{8'h7F, 3'd7, 2'b01, 8'h00};
        vecs[12] = '{8'hC3, 3'd4, 2'b00, 8'h0C};
        for (int i = 0; i < 13; i++) begin
            run_single(vecs[i].d, vecs[i].s, vecs[i].m, res, lat);
            n_checks++;
            if (res !== vecs[i].exp) begin
                n_fail++;
                $display("FAIL directed_value[%0d] in=%h shamt=%0d mode=%b: got %h want %h",
                         i, vecs[i].d, vecs[i].s, vecs[i].m, res, vecs[i].exp);
            end
            n_checks++;
            if (lat !== SW) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, SW); end
            #1;
            n_checks++;
            if (out_valid !== 1'b0 || out_data !== 8'h00) begin
                n_fail++;
                $display("FAIL directed_idle[%0d]: got valid=%b out=%h want 0/00", i, out_valid, out_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ops_d [8];
        logic [2:0] ops_s [8];
        logic [1:0] ops_m [8];
        logic [7:0] expq [$];
        logic [7:0] e;
        logic [7:0] prev_out   = '0;
        logic       prev_stall = 1'b0;
        logic       saw_stall  = 1'b0;
        int         pushed = 0, got = 0, cyc = 0, extra = 0;
        for (int i = 0; i < 8; i++) begin
            ops_d[i] = 8'($urandom); ops_s[i] = 3'($urandom); ops_m[i] = 2'($urandom);
        end
        while ((pushed < 8 || got < 8) && cyc < 60) begin
            in_valid = (pushed < 8);
            if (pushed < 8) begin
                in_data = ops_d[pushed]; in_shamt = ops_s[pushed]; in_mode = ops_m[pushed];
            end
            out_ready = !(cyc >= 4 && cyc <= 7);
            #1;
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== prev_out) begin
                    n_fail++;
                    $display("FAIL b2b_hold cyc %0d: got valid=%b out=%h want 1/%h", cyc, out_valid, out_data, prev_out);
                end
            end
            if (out_ready) begin
                n_checks++;
                if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_on_pop cyc %0d: got %b want 1", cyc, in_ready); end
            end
            if (in_valid && !in_ready) saw_stall = 1'b1;
            if (in_valid && in_ready) begin
                expq.push_back(ref_shift(ops_d[pushed], ops_s[pushed], ops_m[pushed]));
                pushed++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (expq.size() == 0) begin
                    n_fail++; extra++;
                    $display("FAIL b2b_extra cyc %0d: got unexpected %h want none", cyc, out_data);
                end else begin
                    e = expq.pop_front();
                    if (out_data !== e) begin n_fail++; $display("FAIL b2b_value #%0d: got %h want %h", got, out_data, e); end
                end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = out_data;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++; if (saw_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall: got in_ready never low want a stall"); end
        n_checks++; if (got !== 8 || pushed !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d out/%0d in want 8/8", got, pushed); end
        repeat (5) begin
            #1;
            if (out_valid) extra++;
            @(negedge clk);
        end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL b2b_duplicate: got %0d extra results want 0", extra); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] res;
        int         lat;
        int         stale = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'($urandom); in_shamt = 3'($urandom); in_mode = 2'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_inflight: got valid=%b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL midrst_out: got %h want 00", out_data); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            #1;
            if (out_valid) stale++;
            @(negedge clk);
        end
        n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL midrst_stale: got %0d stale cycles want 0", stale); end
        run_single(8'h5A, 3'd1, 2'b01, res, lat);
        n_checks++; if (res !== 8'h2D) begin n_fail++; $display("FAIL midrst_new_value: got %h want 2d", res); end
        n_checks++; if (lat !== SW) begin n_fail++; $display("FAIL midrst_new_latency: got %0d want %0d", lat, SW); end
    endtask

    task automatic test_random();
        logic [7:0] expq [$];
        logic [7:0] e;
        logic [7:0] prev_out   = '0;
        logic       prev_stall = 1'b0;
        int         pushed = 0, got = 0, cyc = 0;
        int         n_ops  = 10000;
        while ((pushed < n_ops || got < n_ops) && cyc < 60000) begin
            if (!in_valid) begin
                in_valid = (pushed < n_ops) && ($urandom_range(0, 3) != 0);
                in_data  = 8'($urandom); in_shamt = 3'($urandom); in_mode = 2'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== prev_out) begin
                    n_fail++;
                    $display("FAIL rnd_hold cyc %0d: got valid=%b out=%h want 1/%h", cyc, out_valid, out_data, prev_out);
                end
            end
            if (!out_valid) begin
                n_checks++;
                if (out_data !== 8'h00) begin n_fail++; $display("FAIL rnd_idle_out cyc %0d: got %h want 00", cyc, out_data); end
            end
            if (out_ready) begin
                n_checks++;
                if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_ready_on_pop cyc %0d: got %b want 1", cyc, in_ready); end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_extra cyc %0d: got unexpected %h want none", cyc, out_data);
                end else begin
                    e = expq.pop_front();
                    if (out_data !== e) begin n_fail++; $display("FAIL rnd_value #%0d: got %h want %h", got, out_data, e); end
                end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = out_data;
            if (in_valid && in_ready) begin
                expq.push_back(ref_shift(in_data, in_shamt, in_mode));
                pushed++;
                @(negedge clk);
                in_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (got !== n_ops || pushed !== n_ops) begin
            n_fail++;
            $display("FAIL rnd_count: got %0d out/%0d in in %0d cycles want %0d/%0d", got, pushed, cyc, n_ops, n_ops);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
